// File: rtl/sysreg_pkg.sv
// Shared register map, control/status bit positions and read default for the sysreg bank.
package sysreg_pkg;

  localparam int unsigned SR_ID0          = 0;
  localparam int unsigned SR_ID1          = 1;
  localparam int unsigned SR_REV          = 2;
  localparam int unsigned SR_STATUS       = 3;
  localparam int unsigned SR_LOG_COUNT    = 4;
  localparam int unsigned SR_LOG_ADDR     = 5;
  localparam int unsigned SR_LOG_DATA     = 6;
  localparam int unsigned SR_CONTROL      = 7;
  localparam int unsigned SR_SCRATCH_BASE = 8;

  localparam int unsigned CTRL_LOG_EN = 0;
  localparam int unsigned CTRL_FLUSH  = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  localparam int unsigned STAT_EMPTY    = 0;
  localparam int unsigned STAT_FULL     = 1;
  localparam int unsigned STAT_OVERFLOW = 2;

  localparam logic [7:0] RD_DEFAULT = 8'hFF;

endpackage

// File: rtl/sysreg_bank_if.sv
// Strobe-bus bundle between a bus master and the sysreg bank.
interface sysreg_bank_if #(
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] a;
  logic [7:0]        d_d;
  logic [7:0]        d_q;
  logic              read_strobe;
  logic              write_strobe;
  logic              irq;

  modport master (output a, d_d, read_strobe, write_strobe, input d_q, irq);
  modport slave  (input a, d_d, read_strobe, write_strobe, output d_q, irq);
endinterface

// File: rtl/sysreg_log_fifo.sv
// Write-log FIFO: push/pop/flush with count, head view and a pulse when a push is dropped.
module sysreg_log_fifo #(
  parameter int unsigned Width = 13,
  parameter int unsigned Depth = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [Width-1:0]       wdata,
  output logic [Width-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count,
  output logic                   dropped
);
  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrW+1)'(Depth));
  assign do_pop  = pop & ~empty & ~flush;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & ~flush & (~full | do_pop);
  assign dropped = push & ~flush & full & ~do_pop;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (do_push && !do_pop) begin
      count_d = count_q + (PtrW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/sysreg_bank.sv
// Byte-wide system register bank: ID/revision, scratch bytes, write-log FIFO, status/control, irq.
module sysreg_bank
  import sysreg_pkg::*;
#(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned N_SCRATCH = 4,
  parameter int unsigned LOG_DEPTH = 8,
  parameter logic [7:0]  ID0       = 8'h42,
  parameter logic [7:0]  ID1       = 8'h73,
  parameter logic [7:0]  REV       = 8'h02
) (
  input logic          clk,
  input logic          rst_n,
  sysreg_bank_if.slave bus
);
  localparam int unsigned EntryW = ADDR_W + 8;
  localparam int unsigned CntW   = $clog2(LOG_DEPTH) + 1;

  logic [7:0]        scratch_q [N_SCRATCH];
  logic              log_en_q, irq_en_q, ovf_q, irq_q;
  logic [7:0]        rd_q, rdata, status, control;
  logic              sel_status, sel_log_data, sel_control, wr_ctrl;
  logic              fifo_push, fifo_pop, fifo_flush;
  logic              fifo_full, fifo_empty, fifo_dropped;
  logic [CntW-1:0]   fifo_count;
  logic [EntryW-1:0] fifo_head;

  assign sel_status   = (bus.a == ADDR_W'(SR_STATUS));
  assign sel_log_data = (bus.a == ADDR_W'(SR_LOG_DATA));
  assign sel_control  = (bus.a == ADDR_W'(SR_CONTROL));
  assign wr_ctrl      = bus.write_strobe & sel_control;

  assign fifo_flush = wr_ctrl & bus.d_d[CTRL_FLUSH];
  assign fifo_push  = bus.write_strobe & ~sel_control & log_en_q;
  assign fifo_pop   = bus.read_strobe & sel_log_data & ~fifo_empty;

  sysreg_log_fifo #(
    .Width (EntryW),
    .Depth (LOG_DEPTH)
  ) u_log_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .wdata   ({bus.a, bus.d_d}),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .dropped (fifo_dropped)
  );

  always_comb begin
    status                = '0;
    status[STAT_EMPTY]    = fifo_empty;
    status[STAT_FULL]     = fifo_full;
    status[STAT_OVERFLOW] = ovf_q;
    control               = '0;
    control[CTRL_LOG_EN]  = log_en_q;
    control[CTRL_IRQ_EN]  = irq_en_q;
  end

  always_comb begin
    rdata = RD_DEFAULT;
    unique case (bus.a)
      ADDR_W'(SR_ID0):       rdata = ID0;
      ADDR_W'(SR_ID1):       rdata = ID1;
      ADDR_W'(SR_REV):       rdata = REV;
      ADDR_W'(SR_STATUS):    rdata = status;
      ADDR_W'(SR_LOG_COUNT): rdata = 8'(fifo_count);
      ADDR_W'(SR_LOG_ADDR):  rdata = fifo_empty ? 8'h00 : 8'(fifo_head[EntryW-1:8]);
      ADDR_W'(SR_LOG_DATA):  rdata = fifo_empty ? 8'h00 : fifo_head[7:0];
      ADDR_W'(SR_CONTROL):   rdata = control;
      default: begin
        for (int unsigned i = 0; i < N_SCRATCH; i++) begin
          if (32'(bus.a) == SR_SCRATCH_BASE + i) rdata = scratch_q[i];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_SCRATCH; i++) scratch_q[i] <= '0;
    end else if (bus.write_strobe) begin
      for (int unsigned i = 0; i < N_SCRATCH; i++) begin
        if (32'(bus.a) == SR_SCRATCH_BASE + i) scratch_q[i] <= bus.d_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log_en_q <= 1'b1;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      rd_q     <= RD_DEFAULT;
    end else begin
      if (wr_ctrl) begin
        log_en_q <= bus.d_d[CTRL_LOG_EN];
        irq_en_q <= bus.d_d[CTRL_IRQ_EN];
      end
      // A drop in the same cycle as a STATUS read wins over the read-clear.
      if (fifo_flush) begin
        ovf_q <= 1'b0;
      end else begin
        ovf_q <= fifo_dropped | (ovf_q & ~(bus.read_strobe & sel_status));
      end
      irq_q <= irq_en_q & (~fifo_empty | ovf_q);
      if (bus.read_strobe) rd_q <= rdata;
    end
  end

  assign bus.d_q = rd_q;
  assign bus.irq = irq_q;

endmodule
